// File: rtl/reg_bank_dbuf.sv
// reg_bank_dbuf: double-buffered register bank, staged writes go live on commit.
// Define REG_BANK_BYPASS_EN to show next-active values combinationally.
module reg_bank_dbuf #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      commit,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic [CHANNELS*WIDTH-1:0] q_flat,
  output logic [CHANNELS-1:0]       dirty,
  output logic                      pending,
  output logic [7:0]                commit_cnt
);

  localparam logic [ADDR_W:0] NCH = (ADDR_W+1)'(CHANNELS);

  logic [WIDTH-1:0]    stage    [CHANNELS];
  logic [WIDTH-1:0]    active   [CHANNELS];
  logic [WIDTH-1:0]    next_act [CHANNELS];
  logic [WIDTH-1:0]    shown    [CHANNELS];
  logic [CHANNELS-1:0] dirty_q;
  logic [CHANNELS-1:0] dirty_d;
  logic [CHANNELS-1:0] wr_hit;
  logic [7:0]          cnt;
  logic                wr_ok;
  logic                do_commit;
  logic                effective;

  assign wr_ok     = wr_en && !reset && ({1'b0, wr_addr} < NCH);
  assign do_commit = commit && !reset;
  // a same-cycle write makes the commit effective on its own
  assign effective = do_commit && ((|dirty_q) || wr_ok);

  always_comb begin
    wr_hit  = '0;
    dirty_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      wr_hit[k]   = wr_ok && (wr_addr == ADDR_W'(k));
      next_act[k] = active[k];
      if (do_commit && wr_hit[k])
        next_act[k] = wr_data;
      else if (do_commit && dirty_q[k])
        next_act[k] = stage[k];
      dirty_d[k] = do_commit ? 1'b0
                 : (dirty_q[k] | wr_hit[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        stage[k]  <= '0;
        active[k] <= '0;
      end
      dirty_q <= '0;
      cnt     <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_hit[k])
          stage[k] <= wr_data;
        active[k] <= next_act[k];
      end
      dirty_q <= dirty_d;
      if (effective)
        cnt <= cnt + 8'd1;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  assign shown = next_act;
`else
  assign shown = active;
`endif

  always_comb begin
    q_flat  = '0;
    rd_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      q_flat[k*WIDTH +: WIDTH] = shown[k];
      if (rd_addr == ADDR_W'(k))
        rd_data = shown[k];
    end
  end

  assign dirty      = dirty_q;
  assign pending    = |dirty_q;
  assign commit_cnt = cnt;

endmodule

// File: tb/tb_reg_bank_dbuf.sv
// tb_reg_bank_dbuf: directed + random checks of two reg_bank_dbuf instances
// (4 and 3 channels) against a behavioural model.
module tb_reg_bank_dbuf;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit;
  logic [1:0]  rd_addr;

  logic [7:0]  rd4, rd3;
  logic [31:0] q4;
  logic [23:0] q3;
  logic [3:0]  d4;
  logic [2:0]  d3;
  logic        p4, p3;
  logic [7:0]  c4, c3;

  int checks = 0;
  int errors = 0;

  int          nch [2] = '{4, 3};
  logic [7:0]  m_stg [2][4];
  logic [7:0]  m_act [2][4];
  bit          m_dty [2][4];
  int          m_cnt [2];

  reg_bank_dbuf #(.WIDTH(8), .CHANNELS(4), .ADDR_W(2)) u4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .rd_addr(rd_addr),
    .rd_data(rd4), .q_flat(q4), .dirty(d4), .pending(p4),
    .commit_cnt(c4)
  );

  reg_bank_dbuf #(.WIDTH(8), .CHANNELS(3), .ADDR_W(2)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .rd_addr(rd_addr),
    .rd_data(rd3), .q_flat(q3), .dirty(d3), .pending(p3),
    .commit_cnt(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_stg[i][k] = '0;
        m_act[i][k] = '0;
        m_dty[i][k] = 1'b0;
      end
      m_cnt[i] = 0;
    end
  endtask

  // One clock edge of the bank: write lands in staging, then commit
  // publishes every dirty channel (so a same-cycle write is included).
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit eff;
      if (wr_en && int'(wr_addr) < nch[i]) begin
        m_stg[i][wr_addr] = wr_data;
        m_dty[i][wr_addr] = 1'b1;
      end
      if (commit) begin
        eff = 1'b0;
        for (int k = 0; k < nch[i]; k++)
          if (m_dty[i][k]) begin
            m_act[i][k] = m_stg[i][k];
            m_dty[i][k] = 1'b0;
            eff = 1'b1;
          end
        if (eff) m_cnt[i] = (m_cnt[i] + 1) % 256;
      end
    end
  endtask

  // Visible value: active, or with bypass the value after this edge.
  function automatic logic [7:0] exp_vis(int i, int k);
    logic [7:0] v;
    if (reset) return 8'h00;
    v = m_act[i][k];
`ifdef REG_BANK_BYPASS_EN
    if (commit) begin
      if (wr_en && int'(wr_addr) == k && k < nch[i])
        v = wr_data;
      else if (m_dty[i][k])
        v = m_stg[i][k];
    end
`endif
    return v;
  endfunction

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] eq;
      logic [3:0]  ed;
      logic [7:0]  er;
      eq = '0;
      ed = '0;
      for (int k = 0; k < nch[i]; k++) begin
        eq[k*8 +: 8] = exp_vis(i, k);
        ed[k] = m_dty[i][k];
      end
      er = (int'(rd_addr) < nch[i]) ? exp_vis(i, int'(rd_addr)) : 8'h00;
      chk($sformatf("%s.q%0d", tag, i),
          (i == 0) ? q4 : {8'h00, q3}, eq);
      chk($sformatf("%s.rd%0d", tag, i),
          32'((i == 0) ? rd4 : rd3), 32'(er));
      chk($sformatf("%s.dirty%0d", tag, i),
          (i == 0) ? 32'(d4) : 32'(d3), 32'(ed));
      chk($sformatf("%s.pend%0d", tag, i),
          32'((i == 0) ? p4 : p3), 32'(|ed));
      chk($sformatf("%s.cnt%0d", tag, i),
          32'((i == 0) ? c4 : c3), 32'(m_cnt[i]));
    end
  endtask

  task automatic cyc(bit we, int wa, int wd, bit cm, int ra, string tag);
    wr_en   = we;
    wr_addr = wa[1:0];
    wr_data = wd[7:0];
    commit  = cm;
    rd_addr = ra[1:0];
    #2 check_all(tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] saved;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; commit = 1'b0; rd_addr = '0;
    model_reset();
    @(negedge clk);
    #2 check_all("rst0");
    reset = 1'b0;
    @(negedge clk);

    // load 0xA5 into ch1, then reset asynchronously mid-cycle
    cyc(1, 1, 8'hA5, 1, 1, "ldA5");
    cyc(0, 0, 0, 0, 1, "seeA5");
    chk("a5_rd", 32'(rd4), 32'h0000_00A5);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A; commit = 1'b1;
    #1 reset = 1'b1;
    model_reset();
    #1 check_all("rst_mid");
    chk("rst_q", q4, 32'h0);
    chk("rst_cnt", 32'(c4), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // staged writes, then commit
    cyc(1, 0, 8'h12, 0, 0, "st0");
    cyc(1, 2, 8'h34, 0, 2, "st2");
    cyc(0, 0, 0, 0, 2, "staged");
    chk("staged_dirty", 32'(d4), 32'h5);
    cyc(0, 0, 0, 1, 0, "commit1");
    cyc(0, 0, 0, 0, 2, "after1");
    chk("after1_q", q4, 32'h0034_0012);
    chk("after1_cnt", 32'(c4), 32'h1);

    // same-cycle write + commit with nothing dirty
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h7F;
    commit = 1'b1; rd_addr = 2'd3;
`ifdef REG_BANK_BYPASS_EN
    #1 chk("byp_rd3", 32'(rd4), 32'h7F);
    #0;
`endif
    cyc(1, 3, 8'h7F, 1, 3, "wc3");
    cyc(0, 0, 0, 0, 3, "after_wc3");
    chk("wc3_rd", 32'(rd4), 32'h7F);
    chk("wc3_cnt", 32'(c4), 32'h2);
    chk("wc3_dirty", 32'(d4), 32'h0);

    // empty commit holds the counter
    cyc(0, 0, 0, 1, 0, "empty");
    cyc(0, 0, 0, 0, 0, "after_empty");
    chk("empty_cnt", 32'(c4), 32'h2);

    // last write wins; out-of-range write on the 3-channel bank
    cyc(1, 1, 8'h01, 0, 1, "lw1");
    cyc(1, 1, 8'h02, 0, 1, "lw2");
    cyc(0, 0, 0, 1, 1, "lwc");
    cyc(1, 3, 8'hEE, 0, 3, "oor");
    cyc(0, 0, 0, 0, 3, "after_oor");
    chk("lw_rd3bank", 32'(q3[15:8]), 32'h02);
    chk("oor_dirty", 32'(d3), 32'h0);
    chk("oor_rd", 32'(rd3), 32'h0);
    cyc(0, 0, 0, 1, 0, "flush");

    for (int n = 0; n < 300; n++)
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 3)), "rnd");

    // 256 effective commits wrap the counter back
    cyc(0, 0, 0, 0, 0, "pre_wrap");
    saved = c4;
    for (int n = 0; n < 256; n++)
      cyc(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
          1, int'($urandom_range(0, 3)), "wrap");
    cyc(0, 0, 0, 0, 0, "post_wrap");
    chk("wrap_cnt", 32'(c4), 32'(saved));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
